// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller with frame-aligned double buffering.
// Optional blanking window between digits is enabled by SEG_SCAN_BLANK_EN.
module seg_scan_ctrl #(
  parameter int REFRESH_DIV = 100_000,
  parameter int BLANK_CYC   = 1_000,
  parameter int DIV_W       = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [27:0] pat_in,
  input  logic [3:0]  en_mask,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        pending,
  output logic        frame_done
);

  typedef enum logic {
    ST_BLANK,
    ST_DRIVE
  } state_e;

`ifdef SEG_SCAN_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  localparam bit HAS_BLANK = BLANK_ON && (BLANK_CYC > 0);
  localparam logic [DIV_W-1:0] LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIV_W-1:0] BLK  = DIV_W'(BLANK_CYC);
  localparam state_e ST_RST = HAS_BLANK ? ST_BLANK : ST_DRIVE;
  localparam logic [27:0] PAT_OFF = {4{7'h7F}};

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  state_e           state_q, state_d;
  logic [27:0]      act_pat_q, act_pat_d;
  logic [3:0]       act_msk_q, act_msk_d;
  logic [27:0]      sh_pat_q, sh_pat_d;
  logic [3:0]       sh_msk_q, sh_msk_d;
  logic             pend_q, pend_d;
  logic             fd_q, fd_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;
  logic             wrap, bnd, show;

  always_comb begin
    wrap  = (cnt_q == LAST);
    bnd   = wrap && (idx_q == 2'd3);
    cnt_d = wrap ? '0 : cnt_q + DIV_W'(1);
    idx_d = wrap ? idx_q + 2'd1 : idx_q;
    fd_d  = bnd;

    act_pat_d = act_pat_q;
    act_msk_d = act_msk_q;
    sh_pat_d  = sh_pat_q;
    sh_msk_d  = sh_msk_q;
    pend_d    = pend_q;
    // A load landing on the boundary skips the shadow entirely.
    if (bnd) begin
      if (load) begin
        act_pat_d = pat_in;
        act_msk_d = en_mask;
      end else if (pend_q) begin
        act_pat_d = sh_pat_q;
        act_msk_d = sh_msk_q;
      end
      pend_d = 1'b0;
    end else if (load) begin
      sh_pat_d = pat_in;
      sh_msk_d = en_mask;
      pend_d   = 1'b1;
    end

    state_d = state_q;
    unique case (state_q)
      ST_BLANK: state_d = (cnt_d >= BLK) ? ST_DRIVE : ST_BLANK;
      ST_DRIVE: state_d = (wrap && HAS_BLANK) ? ST_BLANK : ST_DRIVE;
      default:  state_d = ST_RST;
    endcase

    // Outputs track the next cnt/idx so they land with them on one edge.
    show  = (state_d == ST_DRIVE) && act_msk_d[idx_d];
    seg_d = 7'h7F;
    an_d  = 4'hF;
    if (show) begin
      seg_d = act_pat_d[7*idx_d +: 7];
      an_d  = ~(4'b0001 << idx_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      state_q   <= ST_RST;
      act_pat_q <= PAT_OFF;
      act_msk_q <= 4'b0000;
      sh_pat_q  <= PAT_OFF;
      sh_msk_q  <= 4'b0000;
      pend_q    <= 1'b0;
      fd_q      <= 1'b0;
      seg_q     <= 7'h7F;
      an_q      <= 4'hF;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      state_q   <= state_d;
      act_pat_q <= act_pat_d;
      act_msk_q <= act_msk_d;
      sh_pat_q  <= sh_pat_d;
      sh_msk_q  <= sh_msk_d;
      pend_q    <= pend_d;
      fd_q      <= fd_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign pending    = pend_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (REFRESH_DIV=8, BLANK_CYC=2).
// Expected outputs come from a cycle-count model of the scan schedule.
module tb_seg_scan_ctrl;

  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FR = 4 * RD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [27:0] pat_in = '0;
  logic [3:0]  en_mask = '0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        pending;
  logic        frame_done;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [12:0] expq[$];

  seg_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYC(BC), .DIV_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .pat_in(pat_in),
    .en_mask(en_mask), .seg(seg), .an(an), .pending(pending),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Model: t counts cycles since reset release.
  int t;
  logic [27:0] mp, sp;
  logic [3:0]  mm, sm;
  logic        pd, fdm, bl, bnd;
  logic [1:0]  d;
  int          c;
  logic [6:0]  es;
  logic [3:0]  ea;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t = 0; mp = {4{7'h7F}}; sp = {4{7'h7F}};
      mm = 0; sm = 0; pd = 0; fdm = 0;
      expq.delete();
    end else begin
      bnd = ((t % FR) == FR - 1);
      fdm = bnd;
      if (bnd) begin
        if (load) begin mp = pat_in; mm = en_mask; end
        else if (pd) begin mp = sp; mm = sm; end
        pd = 0;
      end else if (load) begin
        sp = pat_in; sm = en_mask; pd = 1;
      end
      t++;
      c = t % RD;
      d = 2'((t / RD) % 4);
      bl = !mm[d];
`ifdef SEG_SCAN_BLANK_EN
      if (c < BC) bl = 1;
`endif
      es = bl ? 7'h7F : mp[7*d +: 7];
      ea = bl ? 4'hF : ~(4'b0001 << d);
      expq.push_back({es, ea, pd, fdm});
    end
  end

  task automatic tick(output logic [12:0] e, output logic [12:0] g);
    @(posedge clk); #1;
    g = {seg, an, pending, frame_done};
    if (expq.size() == 0) e = 'x;
    else e = expq.pop_front();
    cyc++;
  endtask

  task automatic test_reset();
    rst_n = 0;
    #12;
    n_cmp++; if (seg !== 7'h7F) begin n_bad++; $display("FAIL rst_seg got=%h exp=7f", seg); end
    n_cmp++; if (an !== 4'hF) begin n_bad++; $display("FAIL rst_an got=%h exp=f", an); end
    n_cmp++; if (pending !== 1'b0) begin n_bad++; $display("FAIL rst_pend got=%b exp=0", pending); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL rst_fd got=%b exp=0", frame_done); end
    @(negedge clk);
    rst_n = 1;
    cyc = 0;
  endtask

  task automatic test_buffered_load();
    logic [12:0] e, g;
    while (cyc < 43) begin
      if (cyc == 3) begin
        load = 1; pat_in = {7'h30, 7'h24, 7'h79, 7'h40}; en_mask = 4'hF;
      end
      tick(e, g);
      load = 0;
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL sb_load cyc=%0d got=%h exp=%h", cyc, g, e); end
      if (cyc == 31) begin
        n_cmp++; if (pending !== 1'b1) begin n_bad++; $display("FAIL pend31 got=%b exp=1", pending); end
      end
      if (cyc == 32) begin
        n_cmp++; if ({frame_done, pending} !== 2'b10) begin n_bad++; $display("FAIL fd32 got=%b exp=10", {frame_done, pending}); end
`ifdef SEG_SCAN_BLANK_EN
        n_cmp++; if (an !== 4'hF) begin n_bad++; $display("FAIL blank32 got=%h exp=f", an); end
`else
        n_cmp++; if (an !== 4'b1110) begin n_bad++; $display("FAIL noblank32 got=%h exp=e", an); end
`endif
      end
      if (cyc == 34) begin
        n_cmp++; if ({an, seg} !== {4'b1110, 7'h40}) begin n_bad++; $display("FAIL slot0 got=%h/%h exp=e/40", an, seg); end
      end
      if (cyc == 42) begin
        n_cmp++; if ({an, seg} !== {4'b1101, 7'h79}) begin n_bad++; $display("FAIL slot1 got=%h/%h exp=d/79", an, seg); end
      end
    end
  endtask

  task automatic test_mask();
    logic [12:0] e, g;
    int lit = 0;
    int last_fd = 32;
    load = 1; pat_in = {7'h12, 7'h34, 7'h56, 7'h78}; en_mask = 4'b0101;
    while (cyc < 97) begin
      tick(e, g);
      load = 0;
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL sb_mask cyc=%0d got=%h exp=%h", cyc, g, e); end
      if (cyc >= 64 && cyc < 96 && ((cyc % RD) * 0 + ((cyc / RD) % 2)) == 1 && an !== 4'hF) lit++;
      if (frame_done === 1'b1) begin
        n_cmp++;
        if (cyc - last_fd !== FR) begin n_bad++; $display("FAIL fd_period got=%0d exp=%0d", cyc - last_fd, FR); end
        last_fd = cyc;
      end
    end
    n_cmp++; if (lit !== 0) begin n_bad++; $display("FAIL mask_off got=%0d lit exp=0", lit); end
  endtask

  task automatic test_last_wins();
    logic [12:0] e, g;
    while (cyc < 132) begin
      if (cyc == 98) begin load = 1; pat_in = {{3{7'h7F}}, 7'h00}; en_mask = 4'h1; end
      if (cyc == 105) begin load = 1; pat_in = {{3{7'h7F}}, 7'h7E}; en_mask = 4'h1; end
      tick(e, g);
      load = 0;
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL sb_last cyc=%0d got=%h exp=%h", cyc, g, e); end
      if (cyc == 131) begin
        n_cmp++; if ({an, seg} !== {4'b1110, 7'h7E}) begin n_bad++; $display("FAIL last_wins got=%h/%h exp=e/7e", an, seg); end
      end
    end
  endtask

  task automatic test_bypass();
    logic [12:0] e, g;
    while (cyc < 164) begin
      if (cyc == 135) begin load = 1; pat_in = {{3{7'h7F}}, 7'h5B}; en_mask = 4'h1; end
      if (cyc == 159) begin load = 1; pat_in = {{3{7'h7F}}, 7'h06}; en_mask = 4'h1; end
      tick(e, g);
      load = 0;
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL sb_bypass cyc=%0d got=%h exp=%h", cyc, g, e); end
      if (cyc == 160) begin
        n_cmp++; if (pending !== 1'b0) begin n_bad++; $display("FAIL bypass_pend got=%b exp=0", pending); end
      end
      if (cyc == 163) begin
        n_cmp++; if ({an, seg} !== {4'b1110, 7'h06}) begin n_bad++; $display("FAIL bypass_show got=%h/%h exp=e/06", an, seg); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [12:0] e, g;
    int first_fd = -1;
    while (cyc < 213) begin
      if (cyc == 165) begin load = 1; pat_in = {7'h11, 7'h22, 7'h33, 7'h44}; en_mask = 4'hF; end
      if (cyc == 200) begin load = 1; pat_in = {4{7'h01}}; en_mask = 4'h3; end
      tick(e, g);
      load = 0;
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL sb_pre_rst cyc=%0d got=%h exp=%h", cyc, g, e); end
    end
    n_cmp++; if ({an, seg} !== {4'b1011, 7'h22}) begin n_bad++; $display("FAIL pre_rst_drive got=%h/%h exp=b/22", an, seg); end
    #2 rst_n = 0;
    #1;
    n_cmp++; if ({an, seg, pending, frame_done} !== {4'hF, 7'h7F, 2'b00}) begin
      n_bad++; $display("FAIL mid_rst got=%h/%h/%b%b exp=f/7f/00", an, seg, pending, frame_done);
    end
    @(negedge clk);
    rst_n = 1;
    cyc = 0;
    while (cyc < 34) begin
      tick(e, g);
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL sb_post_rst cyc=%0d got=%h exp=%h", cyc, g, e); end
      if (frame_done === 1'b1 && first_fd < 0) first_fd = cyc;
    end
    n_cmp++; if (first_fd !== FR) begin n_bad++; $display("FAIL post_rst_fd got=%0d exp=%0d", first_fd, FR); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_buffered_load();
    test_mask();
    test_last_wins();
    test_bypass();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexing controller for the 4-digit seven-segment display. It shares the single `seg` bus among the four anodes on a fixed refresh schedule. It double-buffers host-supplied patterns and applies them only at frame boundaries, so the display never shows a torn frame. It sits between the pattern-generating logic (counters, pattern sources) and the board `seg`/`an` pins.

## Interface
- `REFRESH_DIV`, 100_000: clock cycles per digit slot (1 kHz/digit at 100 MHz); legal range ≥ 2.
- `BLANK_CYC`, 1_000: cycles at the start of each slot with all anodes off; legal range < `REFRESH_DIV`.
- `DIV_W`, 17: slot counter width; requires `2**DIV_W ≥ REFRESH_DIV`.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `load` in 1: capture `pat_in`/`en_mask` into the shadow registers this cycle.
- `pat_in` in 28: four 7-bit active-low patterns; digit d = `pat_in[7*d +: 7]`.
- `en_mask` in 4: per-digit enable, 1 = digit shown.
- `seg` out 7: active-low segments, registered.
- `an` out 4: active-low anodes, registered; digit d drives `an[d]`=0.
- `pending` out 1: shadow holds data not yet applied.
- `frame_done` out 1: one-cycle pulse at each frame boundary.

## Operation
- Registers:
  - slot counter `cnt`, 0..`REFRESH_DIV`-1, free-running.
  - digit index `idx`, 0..3.
  - active and shadow pattern/mask registers.
  - `pending`.
- Slot FSM per `idx`:
  - BLANK while `cnt < BLANK_CYC`.
  - DRIVE otherwise.
  - BLANK→DRIVE at `cnt == BLANK_CYC`.
  - DRIVE→BLANK at `cnt == REFRESH_DIV-1`, where `cnt` wraps to 0.
  - When `cnt` wraps, `idx` increments and wraps 3→0.
- Outputs:
  - BLANK: `an`=4'hF, `seg`=7'h7F.
  - DRIVE with active mask bit `idx` = 1: `an` = ~(1<<`idx`), `seg` = active pattern[`idx`].
  - DRIVE with active mask bit `idx` = 0: same outputs as BLANK. The slot still consumes `REFRESH_DIV` cycles, so the refresh rate stays constant.
- Frame boundary: the cycle with `idx==3 && cnt==REFRESH_DIV-1`.
  - At this edge the active registers take the shadow if `pending`, and `pending` clears.
  - `frame_done` is 1 in the cycle following that edge.
- `load` handling:
  - Shadow captures `pat_in`/`en_mask` and `pending` sets.
  - Repeated loads before the boundary overwrite the shadow; the last one wins.
  - A `load` in the frame-boundary cycle bypasses the shadow. Active takes the new `pat_in`/`en_mask` directly and `pending` ends 0.
- Reset (asserted at any time, including mid-slot; async):
  - `cnt`=0, `idx`=0.
  - Active and shadow patterns = 7'h7F each, masks = 4'b0000.
  - `pending`=0, `frame_done`=0, `seg`=7'h7F, `an`=4'hF.

## Timing
- `seg`/`an` are registered on the same edge that updates `cnt`/`idx`, so they always reflect the current `cnt`/`idx`. There is no extra pipeline stage.
- Slot = `REFRESH_DIV` cycles; frame = 4×`REFRESH_DIV` cycles.
- After `rst_n` rises, the first edge sets `cnt`=1. The first digit-0 drive cycle is `cnt==BLANK_CYC`.
- Load-to-display latency is at most one frame plus one slot. New data first appears in slot 0 after the boundary.
- `frame_done` is high exactly 1 cycle every frame. It never fires during reset.
- No internal arithmetic beyond the `cnt` and `idx` wrap-compare.

## Configuration
- `SEG_SCAN_BLANK_EN`:
  - Defined: BLANK phase present as described above.
  - Undefined: `BLANK_CYC` is ignored, the FSM stays in DRIVE for the whole slot, and `an`/`seg` are driven from `cnt`=0.
- Frame timing, `pending`, and `frame_done` are identical in both builds.

## Test plan
Use `REFRESH_DIV`=8, `BLANK_CYC`=2, macro defined unless stated.

- Reset: pulse `rst_n` low mid-slot (`idx`=2, `cnt`=5) → immediately `an`=4'hF, `seg`=7'h7F, `pending`=0. On release, `cnt` restarts at 0 with `idx`=0.
- Buffered load: after reset, `load` at cycle 3 with `pat_in`={7'h30,7'h24,7'h79,7'h40} and `en_mask`=4'hF.
  - `pending`=1 through cycle 31; `frame_done` pulses at cycle 32.
  - Slot 0: `an`=4'hF for 2 cycles, then `an`=4'b1110 with `seg`=7'h40 for 6 cycles.
  - Slot 1: `an`=4'b1101 with `seg`=7'h79.
- Mask: `en_mask`=4'b0101 → slots 1 and 3 fully blank (`an`=4'hF for all 8 cycles); frame stays 32 cycles.
- Last-wins and bypass:
  - Two loads (7'h00 then 7'h7E in digit 0) inside one frame → slot 0 shows 7'h7E.
  - A load asserted in the boundary cycle → `pending`=0 next cycle, and the new pattern shows in the next slot 0.
- Macro undefined: a loaded digit 0 shows `an`=4'b1110 for all 8 cycles of slot 0 with no blank window; `frame_done` period is still 32.
